// File: rtl/jb_axi_regs_if.sv
// rtl/jb_axi_regs_if.sv - register strobe interface between the AXI-Lite bridge and a register block
interface jb_axi_regs_if #(
    parameter int OFFSET_W = 11
);
    logic                wren;
    logic [OFFSET_W-1:0] wr_offset;
    logic [31:0]         wdata;
    logic                rden;
    logic [OFFSET_W-1:0] rd_offset;
    logic [31:0]         rdata;

    modport master (
        output wren, wr_offset, wdata, rden, rd_offset,
        input  rdata
    );

    modport slave (
        input  wren, wr_offset, wdata, rden, rd_offset,
        output rdata
    );
endinterface

// File: rtl/jb_axi_lite_regs_bridge.sv
// rtl/jb_axi_lite_regs_bridge.sv - AXI4-Lite slave to register strobe bridge (JB_REGS_BRIDGE_WSTRB_EN enables byte-merge read-modify-write)
module jb_axi_lite_regs_bridge #(
    parameter int                    AXI_ADDR_W = 32,
    parameter int                    OFFSET_W   = 11,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    jb_axi_regs_if.master         IFP_axi_rw
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_EXEC = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_EXEC = 3'd3,
        ST_WR_RESP = 3'd4
`ifdef JB_REGS_BRIDGE_WSTRB_EN
        , ST_WR_RMW = 3'd5
`endif
    } state_t;

    state_t state, next_state;

    // readies stay low through reset and rise one cycle after release
    logic                  rdy_en;
    logic                  aw_held, w_held, ar_held;
    logic [AXI_ADDR_W-3:0] aw_word, ar_word;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic                  prio_rd;
    logic [OFFSET_W-1:0]   rd_offset_r, wr_offset_r;
    logic [31:0]           wdata_r, rdata_r;
    logic [1:0]            rresp_r, bresp_r;
    logic                  rd_pend, wr_pend, rd_sel, wr_sel;
    logic                  aw_in_range, ar_in_range;
    logic                  unused_addr_bits;

    // byte address bits below word granularity carry no meaning here
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_in_range = (aw_word[AXI_ADDR_W-3:OFFSET_W] == BASE_ADDR[AXI_ADDR_W-1:OFFSET_W+2]);
    assign ar_in_range = (ar_word[AXI_ADDR_W-3:OFFSET_W] == BASE_ADDR[AXI_ADDR_W-1:OFFSET_W+2]);
    assign rd_pend     = ar_held;
    assign wr_pend     = aw_held && w_held;

    assign s_axi_awready = rdy_en && !aw_held;
    assign s_axi_wready  = rdy_en && !w_held;
    assign s_axi_arready = rdy_en && !ar_held;
    assign s_axi_bvalid  = (state == ST_WR_RESP);
    assign s_axi_bresp   = bresp_r;
    assign s_axi_rvalid  = (state == ST_RD_RESP);
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;

    assign IFP_axi_rw.wren      = (state == ST_WR_EXEC);
`ifdef JB_REGS_BRIDGE_WSTRB_EN
    assign IFP_axi_rw.rden      = (state == ST_RD_EXEC) || (state == ST_WR_RMW);
`else
    assign IFP_axi_rw.rden      = (state == ST_RD_EXEC);
`endif
    assign IFP_axi_rw.wr_offset = wr_offset_r;
    assign IFP_axi_rw.wdata     = wdata_r;
    assign IFP_axi_rw.rd_offset = rd_offset_r;

`ifdef JB_REGS_BRIDGE_WSTRB_EN
    logic [31:0] merged_wdata;

    // keep the register's current bytes wherever the write strobe is clear
    always_comb begin
        merged_wdata = IFP_axi_rw.rdata;
        for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) merged_wdata[8*i +: 8] = w_data[8*i +: 8];
        end
    end
`endif

    // state register
    always_ff @(posedge clk or posedge srst) begin
        if (srst) state <= ST_IDLE;
        else      state <= next_state;
    end

    // arbitration between pending read and write, and transaction sequencing
    always_comb begin
        next_state = state;
        rd_sel     = 1'b0;
        wr_sel     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_pend && (prio_rd || !wr_pend)) rd_sel = 1'b1;
                else if (wr_pend)                      wr_sel = 1'b1;
                if (rd_sel) begin
                    next_state = ar_in_range ? ST_RD_EXEC : ST_RD_RESP;
                end else if (wr_sel) begin
                    if (!aw_in_range || (w_strb == 4'h0)) next_state = ST_WR_RESP;
`ifdef JB_REGS_BRIDGE_WSTRB_EN
                    else if (w_strb != 4'hF)             next_state = ST_WR_RMW;
`endif
                    else                                  next_state = ST_WR_EXEC;
                end
            end
            ST_RD_EXEC: next_state = ST_RD_RESP;
            ST_RD_RESP: if (s_axi_rready) next_state = ST_IDLE;
`ifdef JB_REGS_BRIDGE_WSTRB_EN
            ST_WR_RMW:  next_state = ST_WR_EXEC;
`endif
            ST_WR_EXEC: next_state = ST_WR_RESP;
            ST_WR_RESP: if (s_axi_bready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // channel holding registers, strobe payloads and response capture
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            rdy_en      <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            ar_held     <= 1'b0;
            aw_word     <= '0;
            ar_word     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            prio_rd     <= 1'b1;
            rd_offset_r <= '0;
            wr_offset_r <= '0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            rresp_r     <= RESP_OKAY;
            bresp_r     <= RESP_OKAY;
        end else begin
            rdy_en <= 1'b1;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                aw_word <= s_axi_awaddr[AXI_ADDR_W-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (s_axi_arvalid && s_axi_arready) begin
                ar_held <= 1'b1;
                ar_word <= s_axi_araddr[AXI_ADDR_W-1:2];
            end
            if ((state == ST_WR_RESP) && s_axi_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if ((state == ST_RD_RESP) && s_axi_rready) ar_held <= 1'b0;

            if ((rd_sel || wr_sel) && rd_pend && wr_pend) prio_rd <= !prio_rd;

            if (rd_sel) begin
                if (ar_in_range) begin
                    rd_offset_r <= ar_word[OFFSET_W-1:0];
                end else begin
                    rdata_r <= '0;
                    rresp_r <= RESP_SLVERR;
                end
            end
            if (state == ST_RD_EXEC) begin
                rdata_r <= IFP_axi_rw.rdata;
                rresp_r <= RESP_OKAY;
            end

            if (wr_sel) begin
                bresp_r <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                if (next_state == ST_WR_EXEC) begin
                    wr_offset_r <= aw_word[OFFSET_W-1:0];
                    wdata_r     <= w_data;
                end
`ifdef JB_REGS_BRIDGE_WSTRB_EN
                if (next_state == ST_WR_RMW) begin
                    wr_offset_r <= aw_word[OFFSET_W-1:0];
                    rd_offset_r <= aw_word[OFFSET_W-1:0];
                end
`endif
            end
`ifdef JB_REGS_BRIDGE_WSTRB_EN
            if (state == ST_WR_RMW) wdata_r <= merged_wdata;
`endif
        end
    end
endmodule

// File: tb/tb_jb_axi_lite_regs_bridge.sv
// tb/tb_jb_axi_lite_regs_bridge.sv - self-checking bench for jb_axi_lite_regs_bridge
module tb_jb_axi_lite_regs_bridge;
    logic        clk = 1'b0;
    logic        srst;
    logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic        mem_clr;

    jb_axi_regs_if #(.OFFSET_W(11)) rif ();

    jb_axi_lite_regs_bridge #(.AXI_ADDR_W(32), .OFFSET_W(11), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .srst(srst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .IFP_axi_rw(rif)
    );

    always #5 clk = ~clk;

    // register block model: unwritten words read back as A5000000 | offset
    logic [31:0] mem [0:2047];
    logic [2047:0] seen;
    assign rif.rdata = seen[rif.rd_offset] ? mem[rif.rd_offset] : (32'hA500_0000 | {21'b0, rif.rd_offset});
    always @(posedge clk) begin
        if (mem_clr) seen <= '0;
        else if (rif.wren) begin
            mem[rif.wr_offset]  <= rif.wdata;
            seen[rif.wr_offset] <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [10:0] off;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic push(input int kind, input logic [10:0] off, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.kind = kind; e.off = off; e.data = data; e.resp = resp;
        exp_q.push_back(e);
    endtask

    // kinds: 0 rden, 1 wren, 2 read response, 3 write response
    task automatic sb_pop(input int kind, input logic [10:0] off, input logic [31:0] data, input logic [1:0] resp, input string name);
        exp_t e;
        bit ok;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_%s: unexpected event off %h data %h resp %0d, expected nothing", name, off, data, resp);
            return;
        end
        e = exp_q.pop_front();
        ok = (e.kind == kind);
        if (kind <= 1) ok = ok && (e.off == off);
        if (kind == 1 || kind == 2) ok = ok && (e.data == data);
        if (kind >= 2) ok = ok && (e.resp == resp);
        if (ok) n_pass++;
        else $display("FAIL sb_%s: got kind %0d off %h data %h resp %0d, expected kind %0d off %h data %h resp %0d",
                      name, kind, off, data, resp, e.kind, e.off, e.data, e.resp);
    endtask

    int wren_cnt = 0, rden_cnt = 0, overlap_cnt = 0;
    int wren_cyc = 0, rden_cyc = 0, r_rise = 0, b_rise = 0;
    bit rv_prev = 1'b0, bv_prev = 1'b0;

    // monitor: strobes and responses are scored against the expectation queue
    always @(negedge clk) begin
        if (srst) begin
            rv_prev <= 1'b0;
            bv_prev <= 1'b0;
        end else begin
            if (rif.wren && rif.rden) overlap_cnt <= overlap_cnt + 1;
            if (rif.rden) begin
                rden_cnt <= rden_cnt + 1;
                rden_cyc <= cyc;
                sb_pop(0, rif.rd_offset, 32'h0, 2'b00, "rden");
            end
            if (rif.wren) begin
                wren_cnt <= wren_cnt + 1;
                wren_cyc <= cyc;
                sb_pop(1, rif.wr_offset, rif.wdata, 2'b00, "wren");
            end
            if (s_axi_rvalid && !rv_prev) r_rise <= cyc;
            if (s_axi_bvalid && !bv_prev) b_rise <= cyc;
            rv_prev <= s_axi_rvalid;
            bv_prev <= s_axi_bvalid;
            if (s_axi_rvalid && s_axi_rready) sb_pop(2, 11'h0, s_axi_rdata, s_axi_rresp, "rresp");
            if (s_axi_bvalid && s_axi_bready) sb_pop(3, 11'h0, 32'h0, s_axi_bresp, "bresp");
        end
    end

    task automatic drive(input bit da, input bit dw, input bit dr, input logic [31:0] aa,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ra, output int hs);
        bit ah, wh, rh;
        hs = -100;
        @(posedge clk); #1;
        s_axi_awvalid = da; s_axi_awaddr = aa;
        s_axi_wvalid  = dw; s_axi_wdata  = wd; s_axi_wstrb = ws;
        s_axi_arvalid = dr; s_axi_araddr = ra;
        for (int i = 0; i < 30; i++) begin
            if (!(s_axi_awvalid || s_axi_wvalid || s_axi_arvalid)) break;
            @(negedge clk);
            ah = s_axi_awvalid && s_axi_awready;
            wh = s_axi_wvalid && s_axi_wready;
            rh = s_axi_arvalid && s_axi_arready;
            if (ah || wh || rh) hs = cyc;
            @(posedge clk); #1;
            if (ah) s_axi_awvalid = 1'b0;
            if (wh) s_axi_wvalid  = 1'b0;
            if (rh) s_axi_arvalid = 1'b0;
        end
        chk(!(s_axi_awvalid || s_axi_wvalid || s_axi_arvalid), "handshake_timeout",
            {29'b0, s_axi_awvalid, s_axi_wvalid, s_axi_arvalid}, 32'h0);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !s_axi_bvalid && !s_axi_rvalid) begin
                done = 1'b1;
                break;
            end
        end
        chk(done, "done_timeout", exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          strobe;
        logic [10:0] off;
        logic [31:0] exp_data;
        logic [1:0]  resp;
    } vec_t;
    vec_t vt [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs, w0, w1, r0, r1, bad, seen_rv, exp_lat;
        logic [31:0] exp_merge;

        vt[0]  = '{1'b1, 32'h0000_0010, 32'h0012_3456, 4'hF, 1'b1, 11'h004, 32'h0012_3456, 2'b00};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 11'h004, 32'h0012_3456, 2'b00};
        vt[2]  = '{1'b1, 32'h0000_1FFC, 32'h3333_CCCC, 4'hF, 1'b1, 11'h7FF, 32'h3333_CCCC, 2'b00};
        vt[3]  = '{1'b0, 32'h0000_1FFC, 32'h0,         4'h0, 1'b1, 11'h7FF, 32'h3333_CCCC, 2'b00};
        vt[4]  = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 1'b0, 11'h000, 32'h0000_0000, 2'b10};
        vt[5]  = '{1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 1'b0, 11'h000, 32'h0,         2'b10};
        vt[6]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h0, 1'b0, 11'h000, 32'h0,         2'b00};
        vt[7]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 11'h008, 32'hA500_0008, 2'b00};
        vt[8]  = '{1'b1, 32'h0000_002B, 32'h0BAD_F00D, 4'hF, 1'b1, 11'h00A, 32'h0BAD_F00D, 2'b00};
        vt[9]  = '{1'b0, 32'h0000_0029, 32'h0,         4'h0, 1'b1, 11'h00A, 32'h0BAD_F00D, 2'b00};
        vt[10] = '{1'b1, 32'h0000_0044, 32'h1122_3344, 4'hF, 1'b1, 11'h011, 32'h1122_3344, 2'b00};

        srst = 1'b1; mem_clr = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_bready = 1'b1; s_axi_rready = 1'b1;

        // reset state and ready release timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, rif.wren, rif.rden} == 7'b0,
            "reset_outputs", {25'b0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, rif.wren, rif.rden}, 32'h0);
        chk({s_axi_bresp, s_axi_rresp, s_axi_rdata} == 36'h0, "reset_resp_data", s_axi_rdata, 32'h0);
        @(posedge clk); #1;
        srst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk({s_axi_awready, s_axi_wready, s_axi_arready} == 3'b000, "ready_before_edge",
            {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
        @(negedge clk);
        chk({s_axi_awready, s_axi_wready, s_axi_arready} == 3'b111, "ready_after_release",
            {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);

        // simultaneous AW/W/AR: read wins first, then write wins
        push(0, 11'h021, 32'h0, 2'b00);
        push(2, 11'h0, 32'hA500_0021, 2'b00);
        push(1, 11'h020, 32'h5555_AAAA, 2'b00);
        push(3, 11'h0, 32'h0, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 32'h80, 32'h5555_AAAA, 4'hF, 32'h84, hs);
        wait_done();
        push(1, 11'h021, 32'h1234_5678, 2'b00);
        push(3, 11'h0, 32'h0, 2'b00);
        push(0, 11'h020, 32'h0, 2'b00);
        push(2, 11'h0, 32'h5555_AAAA, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 32'h84, 32'h1234_5678, 4'hF, 32'h80, hs);
        wait_done();

        // table of single transactions with latency checks
        for (int i = 0; i < 11; i++) begin
            if (vt[i].strobe) push(vt[i].is_wr ? 1 : 0, vt[i].off, vt[i].exp_data, 2'b00);
            push(vt[i].is_wr ? 3 : 2, 11'h0, vt[i].is_wr ? 32'h0 : vt[i].exp_data, vt[i].resp);
            drive(vt[i].is_wr, vt[i].is_wr, !vt[i].is_wr, vt[i].addr, vt[i].data, vt[i].strb, vt[i].addr, hs);
            wait_done();
            if (vt[i].strobe)
                chk(((vt[i].is_wr ? wren_cyc : rden_cyc) - hs) == 2, $sformatf("strobe_lat_%0d", i),
                    (vt[i].is_wr ? wren_cyc : rden_cyc) - hs, 32'd2);
            chk(((vt[i].is_wr ? b_rise : r_rise) - hs) == (vt[i].strobe ? 3 : 2), $sformatf("resp_lat_%0d", i),
                (vt[i].is_wr ? b_rise : r_rise) - hs, vt[i].strobe ? 32'd3 : 32'd2);
        end

        // partial-strobe write over 0x11223344
`ifdef JB_REGS_BRIDGE_WSTRB_EN
        exp_merge = 32'h1122_CC44;
        exp_lat   = 1;
        push(0, 11'h011, 32'h0, 2'b00);
`else
        exp_merge = 32'hAABB_CCDD;
        exp_lat   = 0;
`endif
        push(1, 11'h011, exp_merge, 2'b00);
        push(3, 11'h0, 32'h0, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 32'h44, 32'hAABB_CCDD, 4'b0010, 32'h0, hs);
        wait_done();
        chk((wren_cyc - hs) == 2 + exp_lat, "wstrb_wren_lat", wren_cyc - hs, 2 + exp_lat);
        chk((b_rise - hs) == 3 + exp_lat, "wstrb_bvalid_lat", b_rise - hs, 3 + exp_lat);
        push(0, 11'h011, 32'h0, 2'b00);
        push(2, 11'h0, exp_merge, 2'b00);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h44, hs);
        wait_done();

        // W two cycles ahead of AW, then write response stalled
        s_axi_bready = 1'b0;
        w0 = wren_cnt;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h7777_8888, 4'hF, 32'h0, hs);
        repeat (2) @(negedge clk);
        chk(wren_cnt == w0, "no_wren_without_aw", wren_cnt - w0, 32'h0);
        push(1, 11'h00C, 32'h7777_8888, 2'b00);
        push(3, 11'h0, 32'h0, 2'b00);
        push(0, 11'h00C, 32'h0, 2'b00);
        push(2, 11'h0, 32'h7777_8888, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, hs);
        for (int i = 0; i < 20; i++) begin
            if (s_axi_bvalid) break;
            @(negedge clk);
        end
        chk(s_axi_bvalid, "bvalid_timeout", {31'b0, s_axi_bvalid}, 32'h1);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h30, hs);
        @(negedge clk);
        w1 = wren_cnt; r1 = rden_cnt; bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!s_axi_bvalid || s_axi_bresp != 2'b00) bad++;
        end
        chk(bad == 0, "bvalid_stable", bad, 32'h0);
        chk(wren_cnt == w1 && rden_cnt == r1, "stall_no_strobe", (wren_cnt - w1) + (rden_cnt - r1), 32'h0);
        chk(wren_cnt == w0 + 1, "single_wren", wren_cnt - w0, 32'h1);
        s_axi_bready = 1'b1;
        wait_done();

        // reset while a read response is stalled
        s_axi_rready = 1'b0;
        push(0, 11'h004, 32'h0, 2'b00);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, hs);
        for (int i = 0; i < 20; i++) begin
            if (s_axi_rvalid) break;
            @(negedge clk);
        end
        chk(s_axi_rvalid, "rvalid_before_reset", {31'b0, s_axi_rvalid}, 32'h1);
        srst = 1'b1;
        #1;
        chk(!s_axi_rvalid, "rvalid_async_clear", {31'b0, s_axi_rvalid}, 32'h0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({s_axi_awready, s_axi_wready, s_axi_arready} == 3'b000, "ready_in_reset",
            {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
        @(posedge clk); #1;
        srst = 1'b0;
        s_axi_rready = 1'b1;
        r0 = rden_cnt; seen_rv = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_axi_rvalid) seen_rv++;
        end
        chk(seen_rv == 0, "no_rvalid_after_reset", seen_rv, 32'h0);
        chk(rden_cnt == r0, "no_rden_after_reset", rden_cnt - r0, 32'h0);
        push(0, 11'h004, 32'h0, 2'b00);
        push(2, 11'h0, 32'h0012_3456, 2'b00);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, hs);
        wait_done();

        chk(overlap_cnt == 0, "wren_rden_overlap", overlap_cnt, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
